// File: rtl/zmod_pkg.sv
// Shared types and constants for the ZMOD PRBS-7 receive checker.
package zmod_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    // x^7 + x^6 + 1
    localparam int PRBS_TAP_A = 7;
    localparam int PRBS_TAP_B = 6;
    localparam int SEED_LEN   = 7;
    localparam int POL_TRIP   = 16;

    // A received bit is in error when it differs from the XOR of the two tap bits.
    function automatic logic prbs_bit_err(input logic d, input logic tap_a, input logic tap_b);
        return d ^ tap_a ^ tap_b;
    endfunction

endpackage

// File: rtl/zmod_prbs_lane.sv
// One self-synchronising PRBS-7 checker lane: history, lock FSM, loss window, counters.
// Optional input auto-inversion is built when ZMOD_PRBS_POLARITY_EN is defined.
module zmod_prbs_lane
    import zmod_pkg::*;
#(
    parameter int LOCK_GOOD   = 64,
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic             i_bit,
    output logic             o_lock,
    output logic             o_loss_sticky,
    output logic             o_polarity,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt
);

    localparam int SEED_W = $clog2(SEED_LEN);
    localparam int GR_W   = $clog2(LOCK_GOOD + 1);
    localparam int WC_W   = $clog2(WINDOW);
    localparam int WE_W   = $clog2(LOSS_THRESH + 1);

    prbs_state_t         r_state, w_state_nxt;
    logic [SEED_LEN-1:0] r_hist, w_hist_nxt;
    logic [SEED_W-1:0]   r_seed_cnt, w_seed_cnt_nxt;
    logic [GR_W-1:0]     r_good_run, w_good_run_nxt;
    logic [WC_W-1:0]     r_win_cnt, w_win_cnt_nxt;
    logic [WE_W-1:0]     r_win_err, w_win_err_nxt;
    logic [CNT_W-1:0]    r_err_cnt, w_err_cnt_nxt;
    logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic                r_loss, w_loss_nxt;
    logic                r_lock;
    logic                w_pol;
    logic                w_d;
    logic                w_err;
    logic                w_err_inc;
    logic                w_bit_inc;
    logic                w_loss_set;

`ifdef ZMOD_PRBS_POLARITY_EN
    localparam int BAD_W = $clog2(POL_TRIP);
    logic             r_pol, w_pol_nxt;
    logic [BAD_W-1:0] r_bad_run, w_bad_run_nxt;
    assign w_pol = r_pol;
`else
    assign w_pol = 1'b0;
`endif

    assign w_d   = i_bit ^ w_pol;
    assign w_err = prbs_bit_err(w_d, r_hist[PRBS_TAP_A-1], r_hist[PRBS_TAP_B-1]);

    // Next-state and datapath decode for the lock FSM and loss window.
    always_comb begin
        w_state_nxt    = r_state;
        w_hist_nxt     = r_hist;
        w_seed_cnt_nxt = r_seed_cnt;
        w_good_run_nxt = r_good_run;
        w_win_cnt_nxt  = r_win_cnt;
        w_win_err_nxt  = r_win_err;
        w_err_inc      = 1'b0;
        w_bit_inc      = 1'b0;
        w_loss_set     = 1'b0;
`ifdef ZMOD_PRBS_POLARITY_EN
        w_pol_nxt      = r_pol;
        w_bad_run_nxt  = r_bad_run;
`endif
        if (!i_enable) begin
            w_state_nxt    = HUNT;
            w_hist_nxt     = '0;
            w_seed_cnt_nxt = '0;
            w_good_run_nxt = '0;
            w_win_cnt_nxt  = '0;
            w_win_err_nxt  = '0;
`ifdef ZMOD_PRBS_POLARITY_EN
            w_bad_run_nxt  = '0;
`endif
        end else if (i_valid) begin
            w_hist_nxt = {r_hist[SEED_LEN-2:0], w_d};
            case (r_state)
                HUNT: begin
                    if (r_seed_cnt == SEED_W'(SEED_LEN - 1)) begin
                        w_state_nxt    = CHECK;
                        w_seed_cnt_nxt = '0;
                        w_good_run_nxt = '0;
`ifdef ZMOD_PRBS_POLARITY_EN
                        w_bad_run_nxt  = '0;
`endif
                    end else begin
                        w_seed_cnt_nxt = r_seed_cnt + SEED_W'(1);
                    end
                end
                CHECK: begin
                    if (w_err) begin
                        w_good_run_nxt = '0;
`ifdef ZMOD_PRBS_POLARITY_EN
                        // A steady run of errors means the lane is inverted: flip and re-seed.
                        if (r_bad_run == BAD_W'(POL_TRIP - 1)) begin
                            w_pol_nxt     = ~r_pol;
                            w_bad_run_nxt = '0;
                            w_state_nxt   = HUNT;
                        end else begin
                            w_bad_run_nxt = r_bad_run + BAD_W'(1);
                        end
`endif
                    end else begin
`ifdef ZMOD_PRBS_POLARITY_EN
                        w_bad_run_nxt = '0;
`endif
                        if (r_good_run == GR_W'(LOCK_GOOD - 1)) begin
                            w_state_nxt    = LOCKED;
                            w_good_run_nxt = '0;
                            w_win_cnt_nxt  = '0;
                            w_win_err_nxt  = '0;
                        end else begin
                            w_good_run_nxt = r_good_run + GR_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    w_bit_inc = 1'b1;
                    w_err_inc = w_err;
                    if (w_err && (r_win_err == WE_W'(LOSS_THRESH - 1))) begin
                        w_state_nxt    = HUNT;
                        w_loss_set     = 1'b1;
                        w_seed_cnt_nxt = '0;
                        w_win_cnt_nxt  = '0;
                        w_win_err_nxt  = '0;
                    end else if (r_win_cnt == WC_W'(WINDOW - 1)) begin
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end else begin
                        w_win_cnt_nxt = r_win_cnt + WC_W'(1);
                        w_win_err_nxt = r_win_err + WE_W'(w_err);
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Saturating counters and sticky loss flag; clear beats increments, a loss beats clear.
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        if (i_clear) begin
            w_err_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
        end else begin
            if (w_err_inc && (r_err_cnt != {CNT_W{1'b1}})) begin
                w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
            end else begin
                w_err_cnt_nxt = r_err_cnt;
            end
            if (w_bit_inc && (r_bit_cnt != {CNT_W{1'b1}})) begin
                w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end else begin
                w_bit_cnt_nxt = r_bit_cnt;
            end
        end
        w_loss_nxt = w_loss_set | (r_loss & ~i_clear);
    end

    // Lane state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= HUNT;
            r_hist     <= '0;
            r_seed_cnt <= '0;
            r_good_run <= '0;
            r_win_cnt  <= '0;
            r_win_err  <= '0;
            r_err_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_loss     <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hist     <= w_hist_nxt;
            r_seed_cnt <= w_seed_cnt_nxt;
            r_good_run <= w_good_run_nxt;
            r_win_cnt  <= w_win_cnt_nxt;
            r_win_err  <= w_win_err_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_loss     <= w_loss_nxt;
            r_lock     <= (w_state_nxt == LOCKED);
        end
    end

`ifdef ZMOD_PRBS_POLARITY_EN
    // Polarity survives enable and clear; only reset returns it to normal.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pol     <= 1'b0;
            r_bad_run <= '0;
        end else begin
            r_pol     <= w_pol_nxt;
            r_bad_run <= w_bad_run_nxt;
        end
    end
`endif

    assign o_lock        = r_lock;
    assign o_loss_sticky = r_loss;
    assign o_polarity    = w_pol;
    assign o_err_cnt     = r_err_cnt;
    assign o_bit_cnt     = r_bit_cnt;

endmodule

// File: rtl/zmod_prbs_checker.sv
// Multi-lane PRBS-7 receive checker for the ZMOD loopback path.
// Define ZMOD_PRBS_POLARITY_EN to build per-lane input auto-inversion.
module zmod_prbs_checker
    import zmod_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int LOCK_GOOD   = 64,
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_W       = 32
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        rx_valid,
    input  logic [LANES-1:0]            rx_data,
    output logic [LANES-1:0]            lock,
    output logic [LANES-1:0]            loss_sticky,
    output logic [LANES-1:0]            polarity,
    output logic [LANES-1:0][CNT_W-1:0] err_cnt,
    output logic [LANES-1:0][CNT_W-1:0] bit_cnt
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        zmod_prbs_lane #(
            .LOCK_GOOD  (LOCK_GOOD),
            .WINDOW     (WINDOW),
            .LOSS_THRESH(LOSS_THRESH),
            .CNT_W      (CNT_W)
        ) u_lane (
            .i_clk        (axi_aclk),
            .i_rst_n      (axi_aresetn),
            .i_enable     (enable),
            .i_clear      (clear),
            .i_valid      (rx_valid),
            .i_bit        (rx_data[g]),
            .o_lock       (lock[g]),
            .o_loss_sticky(loss_sticky[g]),
            .o_polarity   (polarity[g]),
            .o_err_cnt    (err_cnt[g]),
            .o_bit_cnt    (bit_cnt[g])
        );
    end

endmodule

// File: doc/zmod_prbs_checker.md
# zmod_prbs_checker

Receive-side PRBS-7 checker for the ZMOD loopback path. It consumes the 4-lane parallel bit stream recovered from the `zmod_d_in` pairs, one bit per lane per valid beat. Each lane runs its own lock state machine, error counter and bit counter. Counters, lock and loss status are exposed for mapping onto the AXI register file in `slv_read`, and `enable`/`clear` are driven from `slv_reg`.

## Interface
Parameters:
- `LANES`, 4, number of independent lanes
- `LOCK_GOOD`, 64, consecutive error-free beats needed to declare lock
- `WINDOW`, 256, beats per loss-of-lock evaluation window
- `LOSS_THRESH`, 16, errors within one window that drop lock
- `CNT_W`, 32, width of the per-lane error and bit counters

Ports:
- `axi_aclk`, in, 1, sole clock
- `axi_aresetn`, in, 1, asynchronous active-low reset
- `enable`, in, 1, level; low forces all lanes to HUNT
- `clear`, in, 1, single-cycle pulse; zeroes counters and sticky flags
- `rx_valid`, in, 1, `rx_data` is valid this cycle
- `rx_data`, in, `LANES`, one received bit per lane
- `lock`, out, `LANES`, lane is in LOCKED
- `loss_sticky`, out, `LANES`, lane has dropped from LOCKED since the last `clear`
- `polarity`, out, `LANES`, lane input inversion is active
- `err_cnt`, out, `[LANES][CNT_W]`, saturating error count while LOCKED
- `bit_cnt`, out, `[LANES][CNT_W]`, saturating checked-beat count while LOCKED

## Operation
- Polynomial is x^7+x^6+1. Each lane is a self-synchronising checker.
  - History register: `hist <= {hist[5:0], d}` on every valid beat.
  - Prediction is `hist[6]^hist[5]`.
  - `err = d ^ prediction`.
  - `d = rx_data[i] ^ polarity[i]`.
- Per-lane FSM (all updates occur only on `rx_valid`):
  - HUNT: fill `hist`. After 7 valid beats, go to CHECK with `good_run`=0.
  - CHECK: an error clears `good_run`; a good beat increments it. When `good_run` reaches `LOCK_GOOD`, go to LOCKED and zero the window state.
  - LOCKED:
    - `bit_cnt`++ on every beat.
    - On an error: `err_cnt`++ and `win_err`++.
    - `win_cnt`++ on every beat.
    - If `win_err` reaches `LOSS_THRESH`, go to HUNT and set `loss_sticky`.
    - Otherwise, when `win_cnt` wraps at `WINDOW`, zero both `win_cnt` and `win_err`.
- `enable` low: all lanes go to HUNT and `hist`/`good_run`/window state are zeroed. `err_cnt`, `bit_cnt`, `loss_sticky` and `polarity` hold.
- `clear`: zeroes `err_cnt`, `bit_cnt` and `loss_sticky`. FSM state is unaffected.
  - `clear` coincident with an increment: the result is 0.
  - `clear` coincident with a loss event: `loss_sticky` ends at 1 (set wins).
- Counters saturate at 2^`CNT_W`−1 and never wrap.
- A single flipped bit in a locked stream produces exactly 3 errors (at the flipped beat, then 6 and 7 beats later).
- Beats with `rx_valid` low change nothing.

## Timing
- Reset values: all FSMs are in HUNT; `lock`, `loss_sticky`, `polarity`, `err_cnt`, `bit_cnt` and all internal state are 0.
- All outputs are registered. A beat sampled at edge n is reflected in the outputs after edge n (visible in cycle n+1).
- `lock` rises at the edge that samples the beat `7+LOCK_GOOD` valid beats after entering HUNT, assuming clean data.
- `lock` falls at the edge that samples the `LOSS_THRESH`-th error of a window.
- Reset asserted mid-operation clears everything asynchronously. Recovery requires a full HUNT→CHECK→LOCKED sequence.

## Configuration
- `ZMOD_PRBS_POLARITY_EN` defined:
  - In CHECK, 16 consecutive errors with no good beat toggle `polarity[i]`, and the lane returns to HUNT.
  - `polarity` holds through `enable` low. It is cleared only by reset.
- Macro undefined: no auto-inversion logic is built, `polarity` is tied to 0, and a lane receiving inverted data stays in CHECK indefinitely.

## Structure
- Package `zmod_pkg` holds:
  - the `prbs_state_t` enum (HUNT, CHECK, LOCKED);
  - the PRBS-7 tap constants (7, 6);
  - the seed length 7;
  - the polarity trip count 16.
- Sub-module `zmod_prbs_lane` contains one lane's history, FSM, window logic and counters. The top level instantiates `LANES` copies with a generate loop and packs their outputs.

## Test plan
- Clean PRBS-7 on all 4 lanes, `rx_valid` held high, `enable`=1 → `lock`=4'hF visible after the 71st beat; `err_cnt` stays 0; `bit_cnt` increments by 1 per beat.
- Locked, then a single bit flip on lane 2 → `err_cnt[2]`=3, other lanes 0, `lock` stays 4'hF.
- Locked, then 16 flips on lane 0 spread within 256 beats → `lock[0]` falls on the 16th error and `loss_sticky[0]`=1. Clean data afterwards relocks lane 0 after 71 beats.
- `CNT_W`=8 with a continuous error burst while held LOCKED (`LOSS_THRESH`=300) → `err_cnt` saturates at 255. Then `clear` coincident with an error → `err_cnt`=0 and `loss_sticky`=0.
- `rx_valid` toggled 1/0 during clean PRBS → lock timing is counted in valid beats only.
- With `ZMOD_PRBS_POLARITY_EN`, inverted PRBS on lane 1 → `polarity[1]`=1, then `lock[1]`=1 with `err_cnt[1]`=0. Without the macro, `lock[1]` stays 0.
